irq_sequencer: RTL
==================

Name: irq_sequencer

Overview:
- Interrupt controller/sequencer for the 16-bit 5-stage pipelined core (9-bit PC).
- Latches requests from up to NUM_SRC internal sources (switch-change detector, timer, etc.) and arbitrates by fixed priority.
- Flushes the REG/EX/MEM stages, saves the return PC and redirects fetch to a per-source vector.
- Holds off further interrupts until the handler retires a RETI, then restores the PC.

Parameters:
- NUM_SRC, 4, number of interrupt sources (1..8).
- DRAIN_CYCLES, 3, cycles flush masks are held before redirect (1..7).
- VEC_BASE, 9'h1C0, PC of vector for source 0.
- VEC_STRIDE, 9'h008, PC spacing between vectors.

Ports:
- clk  in  1  system clock, all state on rising edge.
- Reset  in  1  synchronous, active-high reset.
- irq_in  in  NUM_SRC  request lines, synchronous to clk, rising-edge sensitive.
- cfg_we  in  1  write enable register: cfg_wdata[15] = global enable, [NUM_SRC-1:0] = source enable mask.
- ack_we  in  1  write-1-to-clear of pending bits using cfg_wdata[NUM_SRC-1:0].
- cfg_wdata  in  16  config/ack write data from MEM stage.
- reti  in  1  one-cycle pulse: RETI instruction retired in WB.
- pc_in  in  9  PC of oldest unretired instruction (return address).
- flush_reg, flush_ex, flush_mem  out  1 each  squash masks for the pipeline registers.
- pc_load  out  1  one-cycle PC redirect strobe.
- pc_target  out  9  redirect address, valid when pc_load=1.
- epc  out  9  saved return PC.
- irq_active  out  1  high from acceptance until return completes.
- irq_id  out  3  source being serviced.
- pending  out  NUM_SRC  pending register.

Behaviour:
- Reset (any state, any cycle): FSM→IDLE; pending, enable mask, global enable, epc, irq_id, edge-history = 0; all outputs 0. Reset wins over every other input that cycle.
- Edge detect: prev <= irq_in each cycle. Rising edge (irq_in & ~prev) on an enabled source sets its pending bit next cycle. A level held high sets it only once.
- Disabled source edges are dropped and do not become pending.
- ack_we clears pending bits where cfg_wdata=1. Same-cycle set and clear on the same bit: set wins.
- cfg_we and ack_we both high: both take effect.
- Clearing an enable bit does not clear that source's already-pending bit.
- Arbitration: lowest-index pending bit wins. Evaluated only in IDLE with global enable=1.
- IDLE: winner exists → FLUSH. On the transition edge: epc <= pc_in, irq_id <= winner, irq_active <= 1.
- FLUSH: flush_reg/ex/mem = 1 for exactly DRAIN_CYCLES cycles via a 3-bit down-counter, then → VECTOR.
- VECTOR: one cycle, pc_load=1, pc_target = (VEC_BASE + irq_id*VEC_STRIDE) mod 512 (9-bit truncation), flushes still high → SERVICE.
- SERVICE: no new acceptance; pending bits keep accumulating. reti=1 → RETURN.
- RETURN: one cycle, pc_load=1, pc_target=epc → IDLE. irq_active drops on entry to IDLE.
- Back-to-back: if a winner exists in that IDLE cycle, FLUSH is entered the next edge (minimum one IDLE cycle between services).
- reti outside SERVICE is ignored.
- The handler must ack its own pending bit; otherwise the same source re-enters after return.
- Latency from irq_in edge to pc_load (default DRAIN_CYCLES=3): pending at +1, FLUSH entered +2, pc_load at +5.

Decomposition:
- Shared package (irq_pkg): FSM state encoding (IDLE, FLUSH, VECTOR, SERVICE, RETURN); cfg bit position GIE=15; default VEC_BASE/VEC_STRIDE constants.
- One sub-module: irq_prio_enc (combinational NUM_SRC→3-bit index + valid, lowest index wins).
- Edge detect, pending register and FSM stay in irq_sequencer.

Test Plan:
- Reset mid-FLUSH (src0 accepted, Reset asserted on 2nd flush cycle) → next cycle all outputs 0, pending=0, state IDLE; src0 does not re-fire.
- Enable all (cfg_wdata=16'h800F), pc_in=9'h045, pulse irq_in[2] → pending=4'b0100 at +1; flushes high for 3 cycles; pc_load with pc_target=9'h1D0 at +5; epc=9'h045; irq_id=2.
- In SERVICE pulse irq_in[0]; ack src2; reti → RETURN pc_target=9'h045; one IDLE cycle; then src0 accepted, pc_target=9'h1C0.
- Simultaneous edges on irq_in[1] and irq_in[3] → irq_id=1 serviced first; pending[3] stays set until its own service.
- Global enable 0 (cfg_wdata=16'h000F), edge on src1 → pending[1]=1 but no FLUSH. Write 16'h800F → acceptance on following cycles.
- Level held high on irq_in[0] across ack → no second set. ack_we and a new rising edge in the same cycle → bit remains set.
- reti pulsed in IDLE → no pc_load.

Source files
------------

// File: rtl/irq_pkg.sv
// Shared constants for the interrupt sequencer: FSM encoding, config bit
// positions, default vector layout and the vector address helper.
package irq_pkg;

    typedef logic [8:0] pc_t;

    localparam logic [2:0] StIdle    = 3'd0;
    localparam logic [2:0] StFlush   = 3'd1;
    localparam logic [2:0] StVector  = 3'd2;
    localparam logic [2:0] StService = 3'd3;
    localparam logic [2:0] StReturn  = 3'd4;

    localparam int unsigned GieBit = 15;

    localparam pc_t DefVecBase   = 9'h1C0;
    localparam pc_t DefVecStride = 9'h008;

    // Vector PC wraps modulo 512 like the fetch PC.
    function automatic pc_t vec_addr(input pc_t base, input pc_t stride, input logic [2:0] id);
        pc_t w_id_ext;
        w_id_ext = {6'd0, id};
        return base + stride * w_id_ext;
    endfunction

endpackage

// File: rtl/irq_sequencer_if.sv
// Pipeline-facing signal bundle of the interrupt sequencer. The master side
// is the core/pipeline, the slave side is the sequencer itself.
interface irq_sequencer_if #(
    parameter int unsigned NUM_SRC = 4
);
    logic [NUM_SRC-1:0] irq_in;
    logic               cfg_we;
    logic               ack_we;
    logic [15:0]        cfg_wdata;
    logic               reti;
    logic [8:0]         pc_in;
    logic               flush_reg;
    logic               flush_ex;
    logic               flush_mem;
    logic               pc_load;
    logic [8:0]         pc_target;
    logic [8:0]         epc;
    logic               irq_active;
    logic [2:0]         irq_id;
    logic [NUM_SRC-1:0] pending;

    modport master (
        output irq_in, cfg_we, ack_we, cfg_wdata, reti, pc_in,
        input  flush_reg, flush_ex, flush_mem, pc_load, pc_target, epc,
               irq_active, irq_id, pending
    );

    modport slave (
        input  irq_in, cfg_we, ack_we, cfg_wdata, reti, pc_in,
        output flush_reg, flush_ex, flush_mem, pc_load, pc_target, epc,
               irq_active, irq_id, pending
    );

endinterface

// File: rtl/irq_prio_enc.sv
// Fixed-priority encoder: returns the lowest-index set request and a valid flag.
module irq_prio_enc #(
    parameter int unsigned NUM_SRC = 4
) (
    input  logic [NUM_SRC-1:0] i_req,
    output logic [2:0]         o_idx,
    output logic               o_valid
);

    // Scan high to low so the lowest set index is the last assignment.
    always_comb begin
        o_idx   = 3'd0;
        o_valid = 1'b0;
        for (int i = NUM_SRC - 1; i >= 0; i--) begin
            if (i_req[i]) begin
                o_idx   = 3'(i);
                o_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/irq_sequencer.sv
// Interrupt sequencer for the 5-stage core: edge-latched pending requests,
// fixed-priority acceptance, pipeline drain, vector redirect and RETI return.
module irq_sequencer
    import irq_pkg::*;
#(
    parameter int unsigned NUM_SRC      = 4,
    parameter int unsigned DRAIN_CYCLES = 3,
    parameter pc_t         VEC_BASE     = DefVecBase,
    parameter pc_t         VEC_STRIDE   = DefVecStride
) (
    input logic            i_clk,
    input logic            i_reset,
    irq_sequencer_if.slave io_bus
);

    localparam logic [2:0] DrainLoad = 3'(DRAIN_CYCLES - 1);

    logic [2:0]         r_state;
    logic [2:0]         w_state_d;
    logic [2:0]         r_cnt;
    logic [NUM_SRC-1:0] r_prev;
    logic [NUM_SRC-1:0] r_pending;
    logic [NUM_SRC-1:0] r_en_mask;
    logic               r_gie;
    pc_t                r_epc;
    logic [2:0]         r_id;

    logic [NUM_SRC-1:0] w_rise;
    logic [NUM_SRC-1:0] w_clr;
    logic [NUM_SRC-1:0] w_pending_d;
    logic [2:0]         w_win_idx;
    logic               w_win_valid;
    logic               w_accept;
    logic               w_unused_wdata;

    assign w_unused_wdata = ^io_bus.cfg_wdata[14:NUM_SRC];

    // Only enabled sources latch; a held level produces a single edge.
    assign w_rise      = io_bus.irq_in & ~r_prev & r_en_mask;
    assign w_clr       = io_bus.ack_we ? io_bus.cfg_wdata[NUM_SRC-1:0] : '0;
    assign w_pending_d = (r_pending & ~w_clr) | w_rise;

    irq_prio_enc #(
        .NUM_SRC(NUM_SRC)
    ) u_prio_enc (
        .i_req  (r_pending),
        .o_idx  (w_win_idx),
        .o_valid(w_win_valid)
    );

    always_comb begin
        w_state_d = r_state;
        w_accept  = 1'b0;
        case (r_state)
            StIdle: begin
                if (r_gie && w_win_valid) begin
                    w_state_d = StFlush;
                    w_accept  = 1'b1;
                end
            end
            StFlush:   if (r_cnt == 3'd0) w_state_d = StVector;
            StVector:  w_state_d = StService;
            StService: if (io_bus.reti) w_state_d = StReturn;
            StReturn:  w_state_d = StIdle;
            default:   w_state_d = StIdle;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            r_state   <= StIdle;
            r_cnt     <= 3'd0;
            r_prev    <= '0;
            r_pending <= '0;
            r_en_mask <= '0;
            r_gie     <= 1'b0;
            r_epc     <= '0;
            r_id      <= 3'd0;
        end else begin
            r_state   <= w_state_d;
            r_prev    <= io_bus.irq_in;
            r_pending <= w_pending_d;
            if (io_bus.cfg_we) begin
                r_gie     <= io_bus.cfg_wdata[GieBit];
                r_en_mask <= io_bus.cfg_wdata[NUM_SRC-1:0];
            end
            if (w_accept) begin
                r_epc <= io_bus.pc_in;
                r_id  <= w_win_idx;
                r_cnt <= DrainLoad;
            end else if (r_state == StFlush && r_cnt != 3'd0) begin
                r_cnt <= r_cnt - 3'd1;
            end
        end
    end

    logic w_flush;
    assign w_flush = (r_state == StFlush) || (r_state == StVector);

    always_comb begin
        io_bus.flush_reg  = w_flush;
        io_bus.flush_ex   = w_flush;
        io_bus.flush_mem  = w_flush;
        io_bus.pc_load    = (r_state == StVector) || (r_state == StReturn);
        io_bus.pc_target  = '0;
        if (r_state == StVector) io_bus.pc_target = vec_addr(VEC_BASE, VEC_STRIDE, r_id);
        if (r_state == StReturn) io_bus.pc_target = r_epc;
        io_bus.epc        = r_epc;
        io_bus.irq_active = (r_state != StIdle);
        io_bus.irq_id     = r_id;
        io_bus.pending    = r_pending;
    end

endmodule
